mul_accumulator: RTL

- Accumulates a programmed number of 8-bit unsigned multiplier products into a wide result, then presents that result on a handshaked output port.
- Sits directly downstream of the 8-bit combinational multiplier in the datapath and consumes its `product` output one beat per accepted handshake.
- Used for dot-product and multiply-accumulate instruction sequences.
- Under `SATURATE` it either clamps or wraps on overflow, and reports overflow through a sticky flag.

---
 rtl/mul_accumulator.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mul_accumulator.sv
// mul_accumulator: sums a programmed number of 8-bit unsigned products into an
// ACC_WIDTH-bit result, then offers that result on a valid/ready output port.
// Overflow either clamps to all-ones (SATURATE=1) or wraps (SATURATE=0); any
// carry out of the accumulator during a run sets a sticky overflow flag.
//
// state | meaning
// IDLE  | waiting for start; result of the previous run still visible
// ACC   | accepting product beats until the beat counter reaches zero
// DONE  | result offered on res_valid until res_ready
module mul_accumulator #(
    parameter int ACC_WIDTH = 16,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_WIDTH-1:0] res_data,
    output logic                 res_ovf,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [8:0]           cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic                 in_ready_q, in_ready_d;
    logic                 res_valid_q, res_valid_d;
    logic                 busy_q, busy_d;

    logic [ACC_WIDTH:0]   sum;
    logic                 beat;

    // Next-state, accumulate and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        beat    = in_valid & in_ready_q;
        // One extra bit so the carry out flags overflow.
        sum     = {1'b0, acc_q} + {{(ACC_WIDTH - 7){1'b0}}, in_data};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = (len == 8'd0) ? 9'd256 : {1'b0, len};
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (beat) begin
                    cnt_d = cnt_q - 9'd1;
                    if (sum[ACC_WIDTH]) begin
                        ovf_d = 1'b1;
                        acc_d = SATURATE ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
                    end else begin
                        acc_d = sum[ACC_WIDTH-1:0];
                    end
                    if (cnt_q == 9'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the next state so no
        // input reaches an output combinationally.
        in_ready_d  = (state_d == ST_ACC);
        res_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 9'd0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = acc_q;
    assign res_ovf   = ovf_q;
    assign busy      = busy_q;

endmodule
